// File: rtl/simple_axis_pkg.sv
// Shared definitions for the simple-stream to AXI4-Stream transmit bridge.
package simple_axis_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  // One FIFO entry at the default data width.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } beat_t;

  // Elaboration-time check for the FIFO depth parameter.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and a
// registered occupancy count. A write into a full FIFO is accepted only when
// a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer and occupancy update; pointers wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/simple_to_axis.sv
// Transmit bridge: buffers beats from a producer without backpressure and
// drains them onto an AXI4-Stream master port under tready control. Beats
// arriving while the buffer is full are dropped and flagged on `overflow`.
// Optional feature macro: SIMPLE_TO_AXIS_FRAME_GEN_EN -- generate tlast from
// a beat counter every FRAME_LEN accepted beats instead of simple_last_in.
module simple_to_axis
  import simple_axis_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      simple_data_in,
  input  logic                   simple_valid_in,
  input  logic                   simple_last_in,
  output logic [DATA_W-1:0]      axi_tdata,
  output logic                   axi_tvalid,
  input  logic                   axi_tready,
  output logic                   axi_tlast,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [$clog2(DEPTH):0] level
);

  if (!is_pow2(DEPTH) || DEPTH < 2 || FRAME_LEN < 1) begin : g_bad_params
    $error("simple_to_axis: DEPTH must be a power of two >= 2 and FRAME_LEN >= 1");
  end

  logic              fifo_full;
  logic              fifo_empty;
  logic              push_ok;
  logic              drop;
  logic              beat_last;
  logic [DATA_W:0]   fifo_head;

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push_ok = simple_valid_in && (!fifo_full || axi_tready);
  assign drop    = simple_valid_in && !push_ok;

`ifdef SIMPLE_TO_AXIS_FRAME_GEN_EN
  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [CNT_W-1:0] frame_cnt;

  assign beat_last = (frame_cnt == CNT_W'(FRAME_LEN - 1));

  // Count accepted beats only, so drops do not shift frame boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (push_ok) begin
      frame_cnt <= beat_last ? '0 : frame_cnt + 1'b1;
    end
  end
`else
  assign beat_last = simple_last_in;
`endif

  // Sticky drop indicator; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (simple_valid_in),
    .wr_data ({simple_data_in, beat_last}),
    .rd_en   (axi_tready),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign axi_tvalid = !fifo_empty;
  assign axi_tdata  = fifo_head[DATA_W:1];
  assign axi_tlast  = fifo_head[0] && !fifo_empty;

endmodule

// File: doc/simple_to_axis.md
# simple_to_axis

Bridge from the internal simple valid/last stream back onto an AXI4-Stream master port. It is the transmit-side counterpart of the AXI-to-simple receive bridge in the audio processing path. The simple producer has no backpressure, so beats are held in a small first-word-fall-through FIFO and drained under AXI `tready` control. Beats that arrive while the FIFO is full are dropped and flagged.

## Interface
- `DATA_W`, default 32: data width of both sides.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two and ≥ 2.
- `FRAME_LEN`, default 256: beats per frame. Used only when `SIMPLE_TO_AXIS_FRAME_GEN_EN` is defined.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `simple_data_in`  in  DATA_W  producer data, sampled when valid.
- `simple_valid_in`  in  1  one-cycle beat strobe. No ready is returned to the producer.
- `simple_last_in`  in  1  end-of-frame marker, sampled with valid.
- `axi_tdata`  out  DATA_W  stream data, taken from the FIFO head.
- `axi_tvalid`  out  1  high whenever the FIFO is not empty.
- `axi_tready`  in  1  downstream ready.
- `axi_tlast`  out  1  last flag of the head beat.
- `overflow`  out  1  sticky flag: a beat was dropped.
- `overflow_clr`  in  1  synchronous clear of `overflow`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: `simple_valid_in` = 1 writes {data, last} at the write pointer.
- Pop: `axi_tvalid && axi_tready` advances the read pointer.
- Pointers are $clog2(DEPTH)+1 bits wide, with a wrap bit.
  - Empty: pointers are equal.
  - Full: indexes are equal and wrap bits differ.
  - Pointers wrap modulo 2·DEPTH with no special casing.
- Full with push and no pop: the beat is dropped, nothing else changes, and `overflow` is set to 1.
- Full with push and pop in the same cycle: the push is accepted and `level` stays at DEPTH.
- Empty with push and no pop: `level` becomes 1. No pop is possible while `axi_tvalid` = 0.
- `overflow` stays set until `overflow_clr` or reset. If set and clear occur in the same cycle, set wins.
- AXI rule: while `axi_tvalid` = 1 and `axi_tready` = 0, `axi_tdata` and `axi_tlast` hold stable. This follows from head-of-FIFO output.
- `axi_tvalid` never depends combinationally on `axi_tready`.

## Timing
- Reset (asynchronous assert, release on a clock edge):
  - Pointers are 0, so the FIFO is empty.
  - `axi_tvalid` = 0, `axi_tlast` = 0, `axi_tdata` = 0.
  - `overflow` = 0, `level` = 0.
- Latency: a beat pushed at edge N appears on `axi_tvalid`/`axi_tdata` in the cycle after edge N.
- Throughput is one beat per cycle when `axi_tready` is held high.
- `level` is registered and updates on the same edge as push/pop.
- Reset mid-frame discards all buffered beats with no `tlast` flush. The downstream receiver resynchronises on the next frame.
- `axi_tdata` comes from memory indexed by a registered pointer; an output register is not required. With an empty FIFO it shows don't-care data, but `axi_tlast` must be 0 whenever `axi_tvalid` = 0.

## Configuration
- `SIMPLE_TO_AXIS_FRAME_GEN_EN` defined:
  - `simple_last_in` is ignored.
  - A beat counter in the push path, range 0..FRAME_LEN-1, forces last = 1 on every FRAME_LEN-th accepted beat, then returns to 0.
  - Dropped beats do not advance the counter.
  - The counter resets to 0.
- Undefined: last is stored from `simple_last_in` unchanged, and no counter logic exists.

## Structure
- Package `simple_axis_pkg`:
  - `DATA_W_DEF` = 32.
  - `typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t` for the FIFO entry.
- Sub-module `sync_fifo`: parameterised FWFT FIFO carrying the pointers, full/empty and level logic.
- The top level holds the overflow flag, the optional frame counter, and the AXI port mapping.

## Test plan
- Single beat: after reset, push 0xA5A5_0001 with last=1 and tready=1 → tvalid in the next cycle with tdata=0xA5A5_0001 and tlast=1; then tvalid=0 and level=0.
- Stall: tready=0, push 3 beats 0x10..0x12 → level=3, tdata held at 0x10 throughout. Release tready → 0x10, 0x11, 0x12 on consecutive cycles.
- Overflow: DEPTH=4, tready=0, push 5 beats → level=4 and overflow=1. The drained beats are the first 4 only. Pulse overflow_clr → overflow=0.
- Full with simultaneous push and pop: fill to 4, then one cycle with tready=1 and a push → level stays 4, overflow=0, order preserved.
- Reset mid-stream: 2 beats buffered, assert reset_n=0 asynchronously → tvalid=0 and level=0 immediately; after release the next push is output alone.
- With `SIMPLE_TO_AXIS_FRAME_GEN_EN` and FRAME_LEN=4: push 8 beats with simple_last_in=0 → tlast=1 on beats 4 and 8 only.
